// File: rtl/booth_share_ctrl_if.sv
// Bus bundle for the shared Booth multiplier: two request/operand/grant
// channels plus the shared status and result signals.
interface booth_share_ctrl_if #(
  parameter int WIDTH = 8
);
  logic               req0;
  logic [WIDTH-1:0]   a0;
  logic [WIDTH-1:0]   b0;
  logic               gnt0;
  logic               req1;
  logic [WIDTH-1:0]   a1;
  logic [WIDTH-1:0]   b1;
  logic               gnt1;
  logic               busy;
  logic               done;
  logic               done_id;
  logic [2*WIDTH-1:0] product;

  // Multiplier side
  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output gnt0, gnt1, busy, done, done_id, product
  );

  // Requester / environment side
  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  gnt0, gnt1, busy, done, done_id, product
  );
endinterface

// File: rtl/booth_share_ctrl.sv
// Radix-2 Booth multiplier shared by two requesters through a round-robin
// arbiter. One operation takes WIDTH RUN cycles plus one DONE cycle; the
// accumulator is one bit wider than the operands so the most negative
// multiplicand cannot overflow the add/subtract step.
module booth_share_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  booth_share_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q,   state_d;
  logic [WIDTH:0]     m_q,       m_d;
  logic [WIDTH:0]     acc_q,     acc_d;
  logic [WIDTH-1:0]   q_q,       q_d;
  logic               q1_q,      q1_d;
  logic [CW-1:0]      cnt_q,     cnt_d;
  logic               owner_q,   owner_d;
  logic               last_q,    last_d;
  logic [2*WIDTH-1:0] prod_q,    prod_d;
  logic               done_q,    done_d;
  logic               done_id_q, done_id_d;

  logic               gnt0_s;
  logic               gnt1_s;
  logic [WIDTH:0]     sum_s;

  // Round-robin grant: only in IDLE and never while reset is asserted
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (!rst && (state_q == S_IDLE)) begin
      if (bus.req0 && bus.req1) begin
        if (last_q) begin
          gnt0_s = 1'b1;
        end else begin
          gnt1_s = 1'b1;
        end
      end else begin
        gnt0_s = bus.req0;
        gnt1_s = bus.req1;
      end
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // Booth recode step: add, subtract or keep the multiplicand
  always_comb begin
    sum_s = acc_q;
    case ({q_q[0], q1_q})
      2'b10:   sum_s = acc_q - m_q;
      2'b01:   sum_s = acc_q + m_q;
      default: sum_s = acc_q;
    endcase
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    q1_d      = q1_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    last_d    = last_q;
    prod_d    = prod_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    case (state_q)
      S_IDLE: begin
        if (gnt0_s || gnt1_s) begin
          state_d = S_RUN;
          m_d     = gnt1_s ? {bus.a1[WIDTH-1], bus.a1} : {bus.a0[WIDTH-1], bus.a0};
          acc_d   = '0;
          q_d     = gnt1_s ? bus.b1 : bus.b0;
          q1_d    = 1'b0;
          cnt_d   = '0;
          owner_d = gnt1_s;
          last_d  = gnt1_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // arithmetic shift of {A,Q,Q_1} after the add/subtract
        acc_d = {sum_s[WIDTH], sum_s[WIDTH:1]};
        q_d   = {sum_s[0], q_q[WIDTH-1:1]};
        q1_d  = q_q[0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // product is captured as DONE is entered so it is visible with done
          state_d   = S_DONE;
          done_d    = 1'b1;
          done_id_d = owner_q;
          prod_d    = {acc_d[WIDTH-1:0], q_d};
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      cnt_q     <= '0;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      prod_q    <= '0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      prod_q    <= prod_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
    end
  end

  assign bus.gnt0    = gnt0_s;
  assign bus.gnt1    = gnt1_s;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
  assign bus.product = prod_q;

endmodule
